// File: rtl/gfx_header_regs_pkg.sv
// Shared types and constants for the scene-header register bank.
package gfx_hdr_pkg;
  typedef enum logic [1:0] {L_IDLE, L_CNT, L_FIELD, L_PEND} loader_e;
  typedef enum logic [1:0] {R_IDLE, R_RUN, R_DONE} run_e;

  localparam int FLD_X     = 0;
  localparam int FLD_Y     = 1;
  localparam int FLD_ANGLE = 2;
  localparam int FLD_ZOOM  = 3;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_NUM_FIELDS = 4;
  localparam int DEF_CNT_W      = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gfx_header_regs_if.sv
// Byte/word-wide valid/ready header stream.
interface gfx_header_regs_if #(parameter int DATA_W = 8);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, s_data, input  s_ready);
  modport slave  (input  s_valid, s_data, output s_ready);
endinterface

// File: rtl/gfx_header_regs_shadow.sv
// Shadow copy of the header being loaded; indexed field write port.
module gfx_hdr_shadow #(
  parameter int DATA_W     = 8,
  parameter int NUM_FIELDS = 4,
  parameter int CNT_W      = 8,
  parameter int IDX_W      = 2
) (
  input  logic                                ACLK,
  input  logic                                reset,
  input  logic                                cnt_we,
  input  logic                                fld_we,
  input  logic [IDX_W-1:0]                    fld_idx,
  input  logic [DATA_W-1:0]                   wdata,
  output logic [CNT_W-1:0]                    shd_cnt,
  output logic [NUM_FIELDS-1:0][DATA_W-1:0]   shd_fld
);
  logic [CNT_W-1:0]                  cnt_q;
  logic [NUM_FIELDS-1:0][DATA_W-1:0] fld_q;

  always_ff @(posedge ACLK) begin
    if (reset) begin
      cnt_q <= '0;
      fld_q <= '0;
    end else begin
      if (cnt_we) cnt_q <= wdata[CNT_W-1:0];
      for (int k = 0; k < NUM_FIELDS; k++)
        if (fld_we && fld_idx == IDX_W'(k)) fld_q[k] <= wdata;
    end
  end

  assign shd_cnt = cnt_q;
  assign shd_fld = fld_q;
endmodule

// File: rtl/gfx_header_regs.sv
// Scene header bank: stream loader into a shadow, committed parameter regs,
// and an object countdown that gates when a pending shadow may be committed.
module gfx_header_regs
  import gfx_hdr_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_FIELDS = DEF_NUM_FIELDS,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                         ACLK,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  gfx_header_regs_if.slave             strm,
  input  logic                         next,
  output logic [NUM_FIELDS*DATA_W-1:0] fields,
  output logic [CNT_W-1:0]             obj_remaining,
  output logic                         hdr_valid,
  output logic                         commit,
  output logic                         finish,
  output logic                         load_busy
);
  localparam int IDX_W = idx_w(NUM_FIELDS);

  loader_e                           ld_q;
  run_e                              rn_q;
  logic [IDX_W-1:0]                  idx_q;
  logic [NUM_FIELDS-1:0][DATA_W-1:0] fields_q, fields_d, shd_fld;
  logic [CNT_W-1:0]                  obj_q, shd_cnt;
  logic                              hdr_valid_q, commit_q, finish_q, load_busy_q;
  logic                              beat, last_beat, do_commit;

  assign strm.s_ready = (ld_q == L_CNT) || (ld_q == L_FIELD);
  assign beat         = strm.s_valid && strm.s_ready && !abort;
  assign last_beat    = beat && (ld_q == L_FIELD) && (idx_q == IDX_W'(NUM_FIELDS-1));
  // Commit only while the run side is not consuming the current header.
  assign do_commit    = !abort && (rn_q != R_RUN) && (last_beat || ld_q == L_PEND);

  gfx_hdr_shadow #(
    .DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .CNT_W(CNT_W), .IDX_W(IDX_W)
  ) u_shadow (
    .ACLK    (ACLK),
    .reset   (reset),
    .cnt_we  (beat && ld_q == L_CNT),
    .fld_we  (beat && ld_q == L_FIELD),
    .fld_idx (idx_q),
    .wdata   (strm.s_data),
    .shd_cnt (shd_cnt),
    .shd_fld (shd_fld)
  );

  // A direct commit lands on the same edge as the last beat, so forward it.
  always_comb begin
    fields_d = shd_fld;
    if (last_beat) fields_d[NUM_FIELDS-1] = strm.s_data;
  end

  always_ff @(posedge ACLK) begin
    if (reset) begin
      ld_q        <= L_IDLE;
      rn_q        <= R_IDLE;
      idx_q       <= '0;
      fields_q    <= '0;
      obj_q       <= '0;
      hdr_valid_q <= 1'b0;
      commit_q    <= 1'b0;
      finish_q    <= 1'b0;
      load_busy_q <= 1'b0;
    end else begin
      commit_q <= do_commit;

      if (abort) begin
        ld_q        <= L_IDLE;
        load_busy_q <= 1'b0;
      end else begin
        case (ld_q)
          L_IDLE: if (start) begin
            ld_q        <= L_CNT;
            load_busy_q <= 1'b1;
          end
          L_CNT: if (beat) begin
            ld_q  <= L_FIELD;
            idx_q <= '0;
          end
          L_FIELD: if (beat) begin
            idx_q <= idx_q + IDX_W'(1);
            if (last_beat) begin
              ld_q        <= do_commit ? L_IDLE : L_PEND;
              load_busy_q <= !do_commit;
            end
          end
          L_PEND: if (do_commit) begin
            ld_q        <= L_IDLE;
            load_busy_q <= 1'b0;
          end
          default: ld_q <= L_IDLE;
        endcase
      end

      if (do_commit) begin
        fields_q <= fields_d;
        obj_q    <= shd_cnt;
        if (shd_cnt == '0) begin
          rn_q        <= R_DONE;
          hdr_valid_q <= 1'b0;
          finish_q    <= 1'b1;
        end else begin
          rn_q        <= R_RUN;
          hdr_valid_q <= 1'b1;
          finish_q    <= 1'b0;
        end
      end else if (rn_q == R_RUN && next) begin
        obj_q <= obj_q - CNT_W'(1);
        if (obj_q == CNT_W'(1)) begin
          rn_q        <= R_DONE;
          hdr_valid_q <= 1'b0;
          finish_q    <= 1'b1;
        end
      end
    end
  end

  assign fields        = fields_q;
  assign obj_remaining = obj_q;
  assign hdr_valid     = hdr_valid_q;
  assign commit        = commit_q;
  assign finish        = finish_q;
  assign load_busy     = load_busy_q;
endmodule

// File: doc/gfx_header_regs.md
# gfx_header_regs

Parametrised header register bank for the graphics-accelerator front end. It captures a per-scene header from a byte-wide valid/ready stream: one object count followed by NUM_FIELDS parameter words (default X centre, Y centre, angle, zoom). It presents the parameters as stable registers and counts objects down on NEXT. A shadow buffer lets the next header load in the background while the current one is still being consumed.

## Interface
- DATA_W, 8, width of each stream beat and each field
- NUM_FIELDS, 4, parameter words following the count beat (≥1)
- CNT_W, 8, object-counter width (≤ DATA_W; count beat truncated to CNT_W LSBs)
- ACLK  in  1  clock
- reset  in  1  synchronous, active-high (reset reset, synchronous, active-high; clock ACLK)
- start  in  1  pulse: arm loader for a new header
- abort  in  1  pulse: discard partially loaded / pending header
- s_valid  in  1  stream beat valid
- s_data  in  DATA_W  stream beat
- s_ready  out  1  loader accepts beat
- next  in  1  pulse: current object consumed
- fields  out  NUM_FIELDS*DATA_W  committed parameters, field k at [k*DATA_W +: DATA_W]
- obj_remaining  out  CNT_W  objects left in committed header
- hdr_valid  out  1  committed header active (run FSM in R_RUN)
- commit  out  1  one-cycle pulse on header commit
- finish  out  1  level: committed header exhausted
- load_busy  out  1  loader not idle

## Operation
- Loader FSM: L_IDLE, L_CNT, L_FIELD, L_PEND. Run FSM: R_IDLE, R_RUN, R_DONE.
- L_IDLE: s_ready=0. On start, go to L_CNT. start in any other loader state is ignored.
- L_CNT: s_ready=1. An accepted beat stores shadow_cnt, clears beat index, and goes to L_FIELD.
- L_FIELD: s_ready=1. An accepted beat stores shadow_field[idx] and increments idx. On beat idx==NUM_FIELDS-1:
  - if run FSM is not in R_RUN, commit on the same edge and go to L_IDLE;
  - else go to L_PEND.
- L_PEND: s_ready=0. Commit when run FSM leaves R_RUN, then go to L_IDLE.
- Commit (registered): fields←shadow, obj_remaining←shadow_cnt, commit=1 for one cycle. Run FSM goes to R_RUN, or to R_DONE if the count is 0.
- R_RUN: next decrements obj_remaining. Decrement from 1 goes to R_DONE.
- R_DONE: finish=1 until the next commit. next in R_IDLE or R_DONE is ignored; no underflow.
- abort: loader goes to L_IDLE, shadow is discarded, and committed state is untouched. abort beats start and any beat on the same edge.
- s_valid while s_ready=0 is ignored and the data is not sampled.
- Reset: both FSMs idle. fields, obj_remaining, hdr_valid, commit, finish, s_ready, load_busy are all 0.

## Timing
- Beat accepted at edge N when s_valid&s_ready. Minimum header load is NUM_FIELDS+1 cycles after the cycle following start.
- Direct commit: the last beat at edge N gives new fields, obj_remaining, hdr_valid, commit in cycle N+1.
- Pending commit: the next that drives R_RUN→R_DONE at edge M commits at edge M+1. finish is high for exactly cycle M+1, then commit/hdr_valid follow.
- next and commit never coincide in R_RUN, because commit only happens outside R_RUN.
- All outputs are registered except s_ready, which decodes the loader state directly.

## Structure
- Package gfx_hdr_pkg:
  - loader and run state enums;
  - field index constants FLD_X=0, FLD_Y=1, FLD_ANGLE=2, FLD_ZOOM=3;
  - default parameter values.
- Sub-module gfx_hdr_shadow: shadow count + NUM_FIELDS×DATA_W shadow registers with a beat-index write port. The top keeps both FSMs and the committed registers.

## Test plan
- Reset, then start and beats 3,0x10,0x20,0x30,0x40. Expect fields=0x40302010, obj_remaining=3, one commit pulse. Three next pulses then give finish=1, hdr_valid=0.
- Count beat 0: commit gives finish=1 immediately, hdr_valid=0. next is ignored and obj_remaining stays 0.
- Background load during R_RUN (obj_remaining=2) enters L_PEND with s_ready=0 and fields unchanged. Two next pulses give finish for one cycle, then new fields commit.
- abort after 2 field beats: load_busy=0, committed fields and obj_remaining are unchanged. A fresh start+header loads correctly.
- s_valid held high with s_ready=0 (L_IDLE and L_PEND): no shadow change. Random s_valid gaps still give the correct field order.
- NUM_FIELDS=6, DATA_W=16 instance: 7 beats load, with field 5 at fields[95:80].
